// File: rtl/vga_timing_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, axis phase encoding
// and the sync/blank bundle carried down the pin-alignment pipeline.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BACK_DEF  = 48;
  localparam int unsigned H_ACT_DEF   = 640;
  localparam int unsigned H_FRONT_DEF = 16;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BACK_DEF  = 33;
  localparam int unsigned V_ACT_DEF   = 480;
  localparam int unsigned V_FRONT_DEF = 10;

  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACT, PH_FRONT} phase_e;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
    logic frame_start;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, frame_start: 1'b0};

  // Total length of one axis (HT for horizontal, VT for vertical).
  function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                             input int unsigned act, input int unsigned front);
    return sync + back + act + front;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM, advancing when adv_i is high.
//   state    | meaning
//   PH_SYNC  | sync pulse asserted, count 0..SYNC-1
//   PH_BACK  | back porch
//   PH_ACT   | visible pixels / lines
//   PH_FRONT | front porch, leaves on wrap
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC  = H_SYNC_DEF,
  parameter int unsigned BACK  = H_BACK_DEF,
  parameter int unsigned ACT   = H_ACT_DEF,
  parameter int unsigned FRONT = H_FRONT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             adv_i,
  output logic [CNT_W-1:0] count_o,
  output phase_e           phase_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] coord_o
);

  localparam int unsigned TOTAL = axis_total(SYNC, BACK, ACT, FRONT);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] B_START = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] A_START = CNT_W'(SYNC + BACK);
  localparam logic [CNT_W-1:0] F_START = CNT_W'(SYNC + BACK + ACT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;
  logic             wrap;

  assign wrap  = adv_i && (cnt_q == LAST);
  assign cnt_d = !adv_i ? cnt_q : (wrap ? '0 : cnt_q + CNT_W'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      phase_q <= PH_SYNC;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Transitions look at the next count so the phase always matches the count it sits beside.
  always_comb begin
    phase_d = phase_q;
    if (adv_i) begin
      case (phase_q)
        PH_SYNC:  if (cnt_d == B_START) phase_d = PH_BACK;
        PH_BACK:  if (cnt_d == A_START) phase_d = PH_ACT;
        PH_ACT:   if (cnt_d == F_START) phase_d = PH_FRONT;
        PH_FRONT: if (wrap)             phase_d = PH_SYNC;
        default:                        phase_d = PH_SYNC;
      endcase
    end
  end

  assign count_o = cnt_q;
  assign phase_o = phase_q;
  assign wrap_o  = wrap;
  assign coord_o = (phase_q == PH_ACT) ? cnt_q - A_START : '0;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster generator and pin driver: requests pixels from a registered source and
// aligns the returned colour with sync/blank on the DAC pins.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned PIX_LATENCY = 1
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic       oRequest,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_n,
  output logic       oFrame_start
);

  localparam int unsigned DLY = PIX_LATENCY + 2;

  logic [CNT_W-1:0] h_cnt, v_cnt, h_coord, v_coord;
  phase_e           h_phase, v_phase;
  logic             h_wrap;
  logic             v_wrap_unused;  // frame boundary is taken from the counts instead

  vga_axis_counter #(.SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .FRONT(H_FRONT)) u_h_axis (
    .clk_i   (iVGA_CLK),
    .rst_n_i (iRST_n),
    .adv_i   (1'b1),
    .count_o (h_cnt),
    .phase_o (h_phase),
    .wrap_o  (h_wrap),
    .coord_o (h_coord)
  );

  vga_axis_counter #(.SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .FRONT(V_FRONT)) u_v_axis (
    .clk_i   (iVGA_CLK),
    .rst_n_i (iRST_n),
    .adv_i   (h_wrap),
    .count_o (v_cnt),
    .phase_o (v_phase),
    .wrap_o  (v_wrap_unused),
    .coord_o (v_coord)
  );

  ctl_t        ctl_now;
  ctl_t        ctl_q [DLY];
  logic        req_q, req_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [29:0] rgb_q, rgb_d;

  // Colour is captured one stage before the pins, so it is gated by the blank bit of that stage.
  always_comb begin
    ctl_now.hs_n        = (h_phase != PH_SYNC);
    ctl_now.vs_n        = (v_phase != PH_SYNC);
    ctl_now.blank_n     = (h_phase == PH_ACT) && (v_phase == PH_ACT);
    ctl_now.frame_start = (h_cnt == '0) && (v_cnt == '0);
    req_d = ctl_now.blank_n;
    x_d   = req_d ? h_coord : '0;
    y_d   = req_d ? v_coord : '0;
    rgb_d = ctl_q[PIX_LATENCY].blank_n ? {iRed, iGreen, iBlue} : '0;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
      for (int i = 0; i < DLY; i++) ctl_q[i] <= CTL_IDLE;
    end else begin
      req_q    <= req_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
      ctl_q[0] <= ctl_now;
      for (int i = 1; i < DLY; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  assign oRequest     = req_q;
  assign oCoord_X     = x_q;
  assign oCoord_Y     = y_q;
  assign oVGA_R       = rgb_q[29:20];
  assign oVGA_G       = rgb_q[19:10];
  assign oVGA_B       = rgb_q[9:0];
  assign oVGA_HS      = ctl_q[DLY-1].hs_n;
  assign oVGA_VS      = ctl_q[DLY-1].vs_n;
  assign oVGA_BLANK_n = ctl_q[DLY-1].blank_n;
  assign oFrame_start = ctl_q[DLY-1].frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: one full-size instance and two shrunken-raster instances
// (latency 1 and 3) fed by echo sources, compared every cycle against a raster model.
module tb_vga_timing_ctrl;

  localparam int NI = 3;

  typedef struct packed {
    int hs; int hb; int ha; int hf;
    int vs; int vb; int va; int vf;
    int lat;
  } tim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] red [NI], green [NI], blue [NI];
  logic [9:0] cx [NI], cy [NI], vr [NI], vg [NI], vb [NI];
  logic       req [NI], hs [NI], vs [NI], bl [NI], fs [NI];

  int n_chk = 0, n_fail = 0;
  int n = 0, seg = 0, len_a = 0;
  bit done = 1'b0;
  int hx [NI][8];
  int hy [NI][8];
  bit hr [NI][8];

  int first_hs_low = -1, last_hs_fall = -1, hs_period = -1, hs_width = -1;
  int bl_rise = -1, bl_lead = -1, bl_width = -1, first_pix = -1, last_x = -1;
  int max_x = -1, max_y = -1;
  int fs1 = -1, fs_gap = -1, vs_fall = -1, vs_width = -1, last_vis = -1, last_pix = -1;
  logic p_hs0 = 1'b1, p_bl0 = 1'b0, p_req0 = 1'b0, p_vs2 = 1'b1;
  int p_cx0 = 0;

  always #20 clk = ~clk;

  vga_timing_ctrl #(.PIX_LATENCY(1)) u_def (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iRed(red[0]), .iGreen(green[0]), .iBlue(blue[0]),
    .oCoord_X(cx[0]), .oCoord_Y(cy[0]), .oRequest(req[0]),
    .oVGA_R(vr[0]), .oVGA_G(vg[0]), .oVGA_B(vb[0]),
    .oVGA_HS(hs[0]), .oVGA_VS(vs[0]), .oVGA_BLANK_n(bl[0]), .oFrame_start(fs[0])
  );

  vga_timing_ctrl #(.H_SYNC(8), .H_BACK(6), .H_ACT(20), .H_FRONT(4),
                    .V_SYNC(2), .V_BACK(3), .V_ACT(10), .V_FRONT(2), .PIX_LATENCY(1)) u_s1 (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iRed(red[1]), .iGreen(green[1]), .iBlue(blue[1]),
    .oCoord_X(cx[1]), .oCoord_Y(cy[1]), .oRequest(req[1]),
    .oVGA_R(vr[1]), .oVGA_G(vg[1]), .oVGA_B(vb[1]),
    .oVGA_HS(hs[1]), .oVGA_VS(vs[1]), .oVGA_BLANK_n(bl[1]), .oFrame_start(fs[1])
  );

  vga_timing_ctrl #(.H_SYNC(8), .H_BACK(6), .H_ACT(20), .H_FRONT(4),
                    .V_SYNC(2), .V_BACK(3), .V_ACT(10), .V_FRONT(2), .PIX_LATENCY(3)) u_s3 (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iRed(red[2]), .iGreen(green[2]), .iBlue(blue[2]),
    .oCoord_X(cx[2]), .oCoord_Y(cy[2]), .oRequest(req[2]),
    .oVGA_R(vr[2]), .oVGA_G(vg[2]), .oVGA_B(vb[2]),
    .oVGA_HS(hs[2]), .oVGA_VS(vs[2]), .oVGA_BLANK_n(bl[2]), .oFrame_start(fs[2])
  );

  function automatic tim_t tim(input int i);
    tim_t t;
    if (i == 0) t = '{96, 48, 640, 16, 2, 33, 480, 10, 1};
    else        t = '{8, 6, 20, 4, 2, 3, 10, 2, (i == 1) ? 1 : 3};
    return t;
  endfunction

  function automatic bit in_act(input tim_t t, input int h, input int v);
    return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.ha) &&
           (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.va);
  endfunction

  // Raster position of cycle m after release is plain division of m by line/frame length.
  function automatic logic [33:0] exp_pins(input int i, input int cyc, input logic [9:0] b);
    tim_t t;
    int m, ht, vt, h, v;
    bit a;
    t  = tim(i);
    ht = t.hs + t.hb + t.ha + t.hf;
    vt = t.vs + t.vb + t.va + t.vf;
    m  = cyc - (t.lat + 2);
    if (m < 0) return {1'b1, 1'b1, 1'b0, 1'b0, 30'd0};
    h = m % ht;
    v = (m / ht) % vt;
    a = in_act(t, h, v);
    return {1'(h >= t.hs), 1'(v >= t.vs), a, 1'(h == 0 && v == 0),
            a ? 10'(h - t.hs - t.hb) : 10'd0, a ? 10'(v - t.vs - t.vb) : 10'd0, a ? b : 10'd0};
  endfunction

  function automatic logic [20:0] exp_stage1(input int i, input int cyc);
    tim_t t;
    int m, ht, vt, h, v;
    bit a;
    t  = tim(i);
    ht = t.hs + t.hb + t.ha + t.hf;
    vt = t.vs + t.vb + t.va + t.vf;
    m  = cyc - 1;
    h  = m % ht;
    v  = (m / ht) % vt;
    a  = in_act(t, h, v);
    return {a, a ? 10'(h - t.hs - t.hb) : 10'd0, a ? 10'(v - t.vs - t.vb) : 10'd0};
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d got %h expected %h", name, inst, n, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_pins"}, i, {hs[i], vs[i], bl[i], fs[i], vr[i], vg[i], vb[i]},
          {1'b1, 1'b1, 1'b0, 1'b0, 30'd0});
      chk({tag, "_stage1"}, i, {req[i], cx[i], cy[i]}, 64'd0);
    end
  endtask

  task automatic measure();
    if (!hs[0] && first_hs_low < 0) first_hs_low = n;
    if (!hs[0] && p_hs0) begin
      if (last_hs_fall >= 0 && hs_period < 0) hs_period = n - last_hs_fall;
      last_hs_fall = n;
    end
    if (hs[0] && !p_hs0 && hs_width < 0) hs_width = n - last_hs_fall;
    if (bl[0] && !p_bl0) begin
      bl_rise = n;
      if (bl_lead < 0) begin
        bl_lead   = n - last_hs_fall;
        first_pix = int'({vr[0], vg[0]});
      end
    end
    if (!bl[0] && p_bl0 && bl_width < 0) bl_width = n - bl_rise;
    if (!req[0] && p_req0 && last_x < 0) last_x = p_cx0;
    if (req[1]) begin
      if (int'(cx[1]) > max_x) max_x = int'(cx[1]);
      if (int'(cy[1]) > max_y) max_y = int'(cy[1]);
    end
    if (bl[2]) last_vis = int'({vr[2], vg[2]});
    if (fs[2]) begin
      if (fs1 < 0) fs1 = n;
      else if (fs_gap < 0) begin
        fs_gap   = n - fs1;
        last_pix = last_vis;
      end
    end
    if (!vs[2] && p_vs2 && vs_fall < 0) vs_fall = n;
    if (vs[2] && !p_vs2 && vs_width < 0 && vs_fall >= 0) vs_width = n - vs_fall;
    p_hs0  = hs[0];
    p_bl0  = bl[0];
    p_req0 = req[0];
    p_cx0  = int'(cx[0]);
    p_vs2  = vs[2];
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) n = 0;
    else if (!done) begin
      n = n + 1;
      if (n == 1) seg = seg + 1;
      for (int i = 0; i < NI; i++) begin
        chk("pins", i, {hs[i], vs[i], bl[i], fs[i], vr[i], vg[i], vb[i]}, exp_pins(i, n, blue[i]));
        chk("stage1", i, {req[i], cx[i], cy[i]}, exp_stage1(i, n));
      end
      if (seg == 1) measure();
    end
    // Echo source: returns the coordinates seen lat cycles ago; junk when that was not a request.
    for (int i = 0; i < NI; i++) begin
      tim_t t;
      t = tim(i);
      for (int k = 7; k > 0; k--) begin
        hx[i][k] = hx[i][k-1];
        hy[i][k] = hy[i][k-1];
        hr[i][k] = hr[i][k-1];
      end
      hx[i][0] = int'(cx[i]);
      hy[i][0] = int'(cy[i]);
      hr[i][0] = req[i];
      if (hr[i][t.lat]) begin
        red[i]   = 10'(hx[i][t.lat]);
        green[i] = 10'(hy[i][t.lat]);
      end else begin
        red[i]   = ($urandom_range(0, 1) == 1) ? 10'd1023 : 10'($urandom_range(0, 1023));
        green[i] = 10'($urandom_range(0, 1023));
      end
      blue[i] = 10'($urandom_range(0, 1023));
    end
  end

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_hold");
    rst_n = 1'b1;
    len_a = 29000 + int'($urandom_range(0, 2000));
    repeat (len_a) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_mid");
    rst_n = 1'b1;
    repeat (2500) @(posedge clk);
    #5 done = 1'b1;

    chk("first_hs_low", 0, first_hs_low, 3);
    chk("hs_period", 0, hs_period, 800);
    chk("hs_width", 0, hs_width, 96);
    chk("blank_lead", 0, bl_lead, 144);
    chk("blank_width", 0, bl_width, 640);
    chk("first_pixel_rg", 0, first_pix, 0);
    chk("last_req_x", 0, last_x, 639);
    chk("max_coord_x", 1, max_x, 19);
    chk("max_coord_y", 1, max_y, 9);
    chk("first_frame_start", 2, fs1, 5);
    chk("frame_period", 2, fs_gap, 646);
    chk("vs_width", 2, vs_width, 76);
    chk("last_pixel_rg", 2, last_pix, 19 * 1024 + 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Drives the VGA DAC and sync pins; it is the consumer end of the pixel-source interface.
- Generates 640x480@60 raster timing and presents pixel coordinates plus a request strobe to a registered pixel source (the colour-bar generator).
- Takes the source's 10-bit RGB back, aligns it with sync/blank through a fixed delay pipeline, and blanks colour outside the active window.

Parameters:
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACT, 640, horizontal active pixels
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACT, 480, vertical active lines
- V_FRONT, 10, vertical front porch
- PIX_LATENCY, 1, clocks from oCoord_X/Y to valid iRed/iGreen/iBlue (range 0..4)

Ports:
- iVGA_CLK  in  1  pixel clock, 25.175 MHz nominal
- iRST_n  in  1  asynchronous active-low reset
- iRed  in  10  pixel-source red
- iGreen  in  10  pixel-source green
- iBlue  in  10  pixel-source blue
- oCoord_X  out  10  active-area column 0..H_ACT-1; 0 outside active
- oCoord_Y  out  10  active-area row 0..V_ACT-1; 0 outside active
- oRequest  out  1  high when oCoord_X/Y name a visible pixel
- oVGA_R  out  10  DAC red
- oVGA_G  out  10  DAC green
- oVGA_B  out  10  DAC blue
- oVGA_HS  out  1  horizontal sync, active low
- oVGA_VS  out  1  vertical sync, active low
- oVGA_BLANK_n  out  1  low during blanking
- oFrame_start  out  1  one-cycle pulse at frame start

Behaviour:
- Line total HT = H_SYNC+H_BACK+H_ACT+H_FRONT (800 by default).
- Frame total VT = V_SYNC+V_BACK+V_ACT+V_FRONT (525 by default).
- Counters:
  - h_cnt runs 0..HT-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..VT-1 and wraps to 0 when both counters wrap together.
- Phase order on each axis is SYNC, BACK, ACTIVE, FRONT, decoded by a 4-state per-axis FSM.
  - SYNC to BACK at count H_SYNC (or V_SYNC).
  - BACK to ACTIVE at SYNC+BACK.
  - ACTIVE to FRONT at SYNC+BACK+ACT.
  - FRONT to SYNC on wrap.
  - The vertical FSM advances only on the h wrap.
- Stage 1, registered from the counters:
  - oRequest = hACTIVE and vACTIVE.
  - oCoord_X = h_cnt-(H_SYNC+H_BACK) when oRequest is high, else 0.
  - oCoord_Y = v_cnt-(V_SYNC+V_BACK) when oRequest is high, else 0.
- The pixel source returns RGB PIX_LATENCY clocks after stage 1.
- Output register captures that RGB, so counter-to-pin latency is PIX_LATENCY+2 clocks.
- hsync_n, vsync_n, blank_n and frame_start pass through a (PIX_LATENCY+2)-deep shift register so pins are mutually aligned.
- oVGA_R/G/B = delayed blank_n ? iRGB : 0. Colour is forced to 0 whenever blank_n is low.
- oFrame_start is high for exactly one clock, aligned with pins for counter state h=0, v=0.
- Reset (iRST_n low, asynchronous):
  - h_cnt and v_cnt = 0; both FSMs = SYNC.
  - oCoord_X, oCoord_Y, oRequest, oVGA_R/G/B, oFrame_start = 0.
  - oVGA_HS and oVGA_VS = 1 (inactive); oVGA_BLANK_n = 0.
  - Delay pipeline is filled with inactive values.
- Release restarts at h=0, v=0 with no partial line carried over.
- A reset mid-line or mid-frame aborts immediately; no glitch pulse on HS/VS after release.
- Width rules:
  - Counters are 10 bits and are sufficient for HT/VT ≤ 1023.
  - Coordinates are 10 bits and never exceed ACT-1.
- Inputs are sampled every clock; the input value while oRequest is low is don't-care because it is masked.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480 timing constants
  - phase enum {PH_SYNC, PH_BACK, PH_ACT, PH_FRONT}
  - HT/VT computation helpers
- Sub-module vga_axis_counter, instanced twice (horizontal and vertical).
  - Parameters: SYNC, BACK, ACT, FRONT.
  - Inputs: clock, reset, advance enable.
  - Outputs: count, phase, wrap pulse, active-relative coordinate.

Test Plan:
- Reset: hold iRST_n low 10 clocks -> HS=1, VS=1, BLANK_n=0, RGB=0, oRequest=0. After release, first HS low edge appears PIX_LATENCY+2 clocks later.
- Line timing: run 3 lines -> HS low exactly 96 clocks per 800-clock period. BLANK_n high exactly 640 clocks per line during active rows, starting 144 clocks after the HS falling edge.
- Frame timing: run 2 full frames -> VS low for exactly 2×800 clocks; frame period 420000 clocks; oFrame_start pulses once per frame, 420000 clocks apart.
- Coordinates: monitor stage 1 -> oCoord_X runs 0..639 with oRequest high; Y steps 0..479. Check the first pixel (0,0) and the last pixel (639,479), and X=Y=0 in blanking.
- Alignment: echo source returns iRed=X[9:0] and iGreen=Y after PIX_LATENCY=1 -> oVGA_R matches column index on the first visible pin cycle (0) and the last (639). oVGA_R=0 in porches even when iRed=1023. Repeat with PIX_LATENCY=3.
- Mid-operation reset: assert iRST_n at h=400, v=200 for 3 clocks -> all outputs take reset values asynchronously. Restart gives a full 800-clock first line and a full frame, with no short sync pulse.
